// File: rtl/seq_sched_pkg.sv
// ----------------------------------------------------------------------------
// seq_sched_pkg
// Shared types and constants for the sequence-detector frame scheduler.
//   DEF_W        : default frame width in bits
//   state_e      : scheduler FSM state encoding
//   id_to_onehot : requester id -> one-hot accept strobe
// ----------------------------------------------------------------------------
package seq_sched_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/seq_frame_sched_if.sv
// ----------------------------------------------------------------------------
// seq_frame_sched_if
// Request and result buses of the frame scheduler.
//   req_valid[1:0]       : per-requester frame valid
//   req_data0/req_data1  : W-bit frame words, MSB shifted first
//   req_ready[1:0]       : one-hot accept strobe
//   res_valid/res_ready  : result handshake
//   res_id               : requester of the reported frame
//   res_ycnt/res_zcnt    : detector pulse counts for the frame
// Modports: master = requesters/result consumer, slave = scheduler.
// ----------------------------------------------------------------------------
interface seq_frame_sched_if #(
    parameter int W = seq_sched_pkg::DEF_W
);
    localparam int CW = $clog2(W + 1);

    logic [1:0]    req_valid;
    logic [W-1:0]  req_data0;
    logic [W-1:0]  req_data1;
    logic [1:0]    req_ready;
    logic          res_valid;
    logic          res_ready;
    logic          res_id;
    logic [CW-1:0] res_ycnt;
    logic [CW-1:0] res_zcnt;

    modport master (
        output req_valid, req_data0, req_data1, res_ready,
        input  req_ready, res_valid, res_id, res_ycnt, res_zcnt
    );

    modport slave (
        input  req_valid, req_data0, req_data1, res_ready,
        output req_ready, res_valid, res_id, res_ycnt, res_zcnt
    );

endinterface

// File: rtl/seq_frame_sched_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone request is always granted; on a tie the
// requester not granted last wins. The last-grant pointer resets to 1 so
// requester 0 wins the first tie.
//   clk, rst : clock, async active-low reset
//   req[1:0] : request vector
//   adv      : commit the current grant to the last-grant pointer
//   gnt[1:0] : one-hot grant (combinational)
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt    = req;
        last_d = last_q;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
        if (adv && (req != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, matching the hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/seq_frame_sched.sv
// ----------------------------------------------------------------------------
// seq_frame_sched
// Shares one serial sequence detector between two frame requesters. For each
// granted frame: clear the detector for one cycle, shift the frame out MSB
// first, count detector y/z pulses, then report id and counts.
//   clk, rst   : clock, async active-low reset
//   bus        : request/result buses (seq_frame_sched_if.slave)
//   x_out      : serial bit to the detector, registered
//   det_rst_n  : detector reset, active-low, registered
//   y_in, z_in : detector outputs (registered in the detector)
// ----------------------------------------------------------------------------
module seq_frame_sched
    import seq_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic               clk,
    input  logic               rst,
    seq_frame_sched_if.slave   bus,
    output logic               x_out,
    output logic               det_rst_n,
    input  logic               y_in,
    input  logic               z_in
);

    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LAST_BIT = IW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [IW-1:0] bit_q, bit_d;
    logic          id_q, id_d;
    logic [CW-1:0] ycnt_q, ycnt_d;
    logic [CW-1:0] zcnt_q, zcnt_d;
    logic [1:0]    req_ready_q, req_ready_d;
    logic          x_out_q, x_out_d;
    logic          det_rst_n_q, det_rst_n_d;

    logic [1:0]    gnt;
    logic          any_req;

    assign any_req = |bus.req_valid;

    // Pointer only advances on a real grant, which happens in IDLE alone.
    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.req_valid),
        .adv (state_q == ST_IDLE),
        .gnt (gnt)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_d       = bit_q;
        id_d        = id_q;
        ycnt_d      = ycnt_q;
        zcnt_d      = zcnt_q;
        req_ready_d = 2'b00;
        x_out_d     = 1'b0;
        det_rst_n_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d     = ST_CLEAR;
                    shreg_d     = gnt[1] ? bus.req_data1 : bus.req_data0;
                    id_d        = gnt[1];
                    ycnt_d      = '0;
                    zcnt_d      = '0;
                    req_ready_d = id_to_onehot(gnt[1]);
                    det_rst_n_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                // Pre-load the first bit so x_out is valid in SHIFT cycle 0.
                state_d = ST_SHIFT;
                bit_d   = '0;
                x_out_d = shreg_q[W-1];
                shreg_d = shreg_q << 1;
            end
            ST_SHIFT: begin
                // Detector output lags x by one cycle; SHIFT cycle 0 still
                // shows the cleared detector, so it is not counted.
                if (bit_q != '0) begin
                    ycnt_d = ycnt_q + CW'(y_in);
                    zcnt_d = zcnt_q + CW'(z_in);
                end
                // After W shifts the register is all zero, so the last SHIFT
                // cycle naturally loads x_out=0 for DRAIN.
                x_out_d = shreg_q[W-1];
                shreg_d = shreg_q << 1;
                if (bit_q == LAST_BIT) begin
                    state_d = ST_DRAIN;
                end else begin
                    bit_d = bit_q + IW'(1);
                end
            end
            ST_DRAIN: begin
                ycnt_d  = ycnt_q + CW'(y_in);
                zcnt_d  = zcnt_q + CW'(z_in);
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All scheduler flops, datapath included, return to known values so an
    // aborted frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_q       <= '0;
            id_q        <= 1'b0;
            ycnt_q      <= '0;
            zcnt_q      <= '0;
            req_ready_q <= 2'b00;
            x_out_q     <= 1'b0;
            det_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            id_q        <= id_d;
            ycnt_q      <= ycnt_d;
            zcnt_q      <= zcnt_d;
            req_ready_q <= req_ready_d;
            x_out_q     <= x_out_d;
            det_rst_n_q <= det_rst_n_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = (state_q == ST_RESULT);
    assign bus.res_id    = id_q;
    assign bus.res_ycnt  = ycnt_q;
    assign bus.res_zcnt  = zcnt_q;
    assign x_out         = x_out_q;
    assign det_rst_n     = det_rst_n_q;

endmodule

// File: tb/tb_seq_frame_sched.sv
// ----------------------------------------------------------------------------
// tb_seq_frame_sched
// Self-checking bench for seq_frame_sched with a detector stub
// (y = x registered, z = ~x registered, both cleared by det_rst_n).
// Expected values come from frame-level rules: round-robin grant choice,
// ycnt = number of ones in the frame, zcnt = number of zeros.
// ----------------------------------------------------------------------------
module tb_seq_frame_sched;
    import seq_sched_pkg::*;

    localparam int W  = DEF_W;
    localparam int CW = $clog2(W + 1);

    logic clk;
    logic rst;
    logic x_out;
    logic det_rst_n;
    logic y_in;
    logic z_in;

    seq_frame_sched_if #(.W(W)) bus ();

    seq_frame_sched #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .x_out     (x_out),
        .det_rst_n (det_rst_n),
        .y_in      (y_in),
        .z_in      (z_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector stub
    always_ff @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            y_in <= 1'b0;
            z_in <= 1'b0;
        end else begin
            y_in <= x_out;
            z_in <= ~x_out;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit model_last = 1'b1;   // id of the requester granted last

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ones(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_x_out"},     32'(x_out),         32'd0);
        check({tag, "_det_rst_n"}, 32'(det_rst_n),     32'd0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_res_id"},    32'(bus.res_id),    32'd0);
        check({tag, "_ycnt"},      32'(bus.res_ycnt),  32'd0);
        check({tag, "_zcnt"},      32'(bus.res_zcnt),  32'd0);
    endtask

    // Runs one frame end to end. Called at a negedge while the DUT is idle
    // with req_valid already set; returns at the negedge of the idle cycle
    // that follows the result handshake.
    task automatic run_txn(input bit refill, input int bp);
        bit           exp_id;
        logic [W-1:0] word;
        int           exp_y;
        int           exp_z;

        if (bus.req_valid == 2'b11) exp_id = ~model_last;
        else                        exp_id = bus.req_valid[1];
        word       = exp_id ? bus.req_data1 : bus.req_data0;
        model_last = exp_id;
        exp_y      = ones(word);
        exp_z      = W - exp_y;
        bus.res_ready = (bp == 0);

        @(negedge clk);  // CLEAR
        check("grant_ready", 32'(bus.req_ready), exp_id ? 32'd2 : 32'd1);
        check("clear_det_rst_n", 32'(det_rst_n), 32'd0);
        check("clear_res_valid", 32'(bus.res_valid), 32'd0);
        if (refill) begin
            if (exp_id) bus.req_data1 = W'($urandom);
            else        bus.req_data0 = W'($urandom);
        end else begin
            bus.req_valid[exp_id] = 1'b0;
        end

        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("shift_x", 32'(x_out), 32'(word[W-1-i]));
            check("shift_det_rst_n", 32'(det_rst_n), 32'd1);
            check("shift_req_ready", 32'(bus.req_ready), 32'd0);
        end

        @(negedge clk);  // DRAIN
        check("drain_x", 32'(x_out), 32'd0);
        check("drain_res_valid", 32'(bus.res_valid), 32'd0);

        @(negedge clk);  // first RESULT cycle, grant + W + 3
        check("res_valid", 32'(bus.res_valid), 32'd1);
        check("res_id",    32'(bus.res_id),    32'(exp_id));
        check("res_ycnt",  32'(bus.res_ycnt),  32'(exp_y));
        check("res_zcnt",  32'(bus.res_zcnt),  32'(exp_z));

        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            check("bp_valid",     32'(bus.res_valid), 32'd1);
            check("bp_id",        32'(bus.res_id),    32'(exp_id));
            check("bp_ycnt",      32'(bus.res_ycnt),  32'(exp_y));
            check("bp_zcnt",      32'(bus.res_zcnt),  32'(exp_z));
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_det_rst_n", 32'(det_rst_n),     32'd1);
        end
        bus.res_ready = 1'b1;

        @(negedge clk);  // back in IDLE
        check("post_res_valid", 32'(bus.res_valid), 32'd0);
        check("post_req_ready", 32'(bus.req_ready), 32'd0);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);
        check("det_rst_n_rise", 32'(det_rst_n), 32'd1);
        check("idle_res_valid", 32'(bus.res_valid), 32'd0);

        // Single frame from req0
        bus.req_data0 = 8'hA5;
        bus.req_valid = 2'b01;
        run_txn(1'b0, 0);

        // Backpressure with a competing request pending during RESULT;
        // the waiting requester is granted right after the handshake.
        bus.req_data0 = W'($urandom);
        bus.req_data1 = W'($urandom);
        bus.req_valid = 2'b11;
        run_txn(1'b0, 20);
        run_txn(1'b0, 0);

        // Tie straight out of reset: req0 wins, then req1
        rst           = 1'b0;
        model_last    = 1'b1;
        bus.req_data0 = 8'hFF;
        bus.req_data1 = 8'h00;
        bus.req_valid = 2'b11;
        @(negedge clk);
        rst = 1'b1;
        run_txn(1'b0, 0);
        run_txn(1'b0, 0);

        // Fairness: both keep requesting for six frames
        bus.req_data0 = W'($urandom);
        bus.req_data1 = W'($urandom);
        bus.req_valid = 2'b11;
        for (int f = 0; f < 6; f++) run_txn(1'b1, 0);

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            if (bus.req_valid == 2'b00) begin
                bus.req_valid = 2'($urandom_range(1, 3));
                if (bus.req_valid[0]) bus.req_data0 = W'($urandom);
                if (bus.req_valid[1]) bus.req_data1 = W'($urandom);
            end
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset in the middle of SHIFT
        bus.req_valid = 2'b00;
        @(negedge clk);
        bus.req_data0 = 8'hF0;
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("midrst_grant", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;
        repeat (4) @(negedge clk);   // now in SHIFT bit 3
        check("midrst_bit3_x", 32'(x_out), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            check("midrst_no_result", 32'(bus.res_valid), 32'd0);
            check("midrst_no_ready",  32'(bus.req_ready), 32'd0);
        end

        bus.req_data0 = 8'h0F;
        bus.req_valid = 2'b01;
        run_txn(1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_frame_sched.md
# seq_frame_sched

Front-end scheduler for the team's serial sequence-detector FSM (`x` in; registered `y`, `z` out). It accepts W-bit frames from two requesters and arbitrates between them round-robin. For each granted frame it clears the detector, shifts the frame in MSB-first, counts `y` and `z` pulses over the frame, and returns the counts with the requester id through a valid/ready result port. It sits between the two frame sources and one detector instance, so the detector can be shared without glitches or cross-frame state leakage.

## Interface
- `W`, 8: frame width in bits, ≥2.
- `CW`, `$clog2(W+1)`: count width (localparam).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 2: per-requester frame valid.
- `req_data0`, `req_data1` in W: frame words, MSB shifted first.
- `req_ready` out 2: one-hot accept strobe, registered.
- `x_out` out 1: serial bit to the detector `x`.
- `det_rst_n` out 1: detector reset, active-low, registered.
- `y_in`, `z_in` in 1: detector outputs.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumed.
- `res_id` out 1: requester of the reported frame.
- `res_ycnt`, `res_zcnt` out CW: pulse counts for the frame.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, RESULT.
- **IDLE**
  - If any `req_valid` is high: grant one requester, latch its word into a shift register, latch the id, zero both counts, then go to CLEAR.
  - `req_ready[id]` is high for exactly the cycle after the grant decision. The requester must hold `req_data*` stable while `req_valid` is high until it sees `req_ready`.
- **Arbitration**
  - A lone requester is always granted.
  - If both request, grant the one not granted last.
  - The last-grant pointer resets to 1, so req0 wins the first tie.
- **CLEAR**: one cycle, `det_rst_n`=0; then go to SHIFT with bit index 0.
- **SHIFT**: W cycles. `x_out` = word[W-1-i] in cycle i; the detector samples it at the end of that cycle.
- **Counting alignment**: detector outputs for the bit sampled at the end of cycle i are visible in cycle i+1. Counts therefore add `y_in`/`z_in` in SHIFT cycles 1..W-1 and in DRAIN. The first SHIFT cycle is ignored; the detector is freshly cleared then.
- **DRAIN**: one cycle, `x_out`=0, final count accumulation; then go to RESULT.
- **RESULT**
  - `res_valid`=1, with `res_id`, `res_ycnt`, `res_zcnt` stable.
  - On `res_valid & res_ready`, return to IDLE. There is no direct RESULT→CLEAR path.
  - `req_valid` activity during RESULT is ignored until IDLE.
- **Width**: counts saturate at W by construction (at most W contributing samples), so there is no overflow.
- **Reset values**: `req_ready`=0, `x_out`=0, `det_rst_n`=0, `res_valid`=0, `res_id`=0, counts 0, state IDLE.
- **`det_rst_n` after reset**: it rises to 1 on the first clock after `rst` deasserts, unless that cycle enters CLEAR.
- **Reset mid-operation**: abort immediately. The frame is dropped with no result. Requesters see no `req_ready` for it if the grant has not yet been strobed.

## Timing
- The grant decision is made in the IDLE cycle T.
  - T+1: CLEAR and `req_ready` pulse.
  - T+2 … T+W+1: SHIFT.
  - T+W+2: DRAIN.
  - T+W+3 onward: `res_valid`.
- Minimum frame-to-frame spacing is W+4 cycles with `res_ready` tied high.
- `det_rst_n` and `x_out` come straight from flops, with no combinational path from inputs.
- `res_valid` falls the cycle after the handshake.

## Structure
- Package `seq_sched_pkg`: state encoding localparams, default W.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with a last-grant register. Inputs: request vector and an advance enable. Output: one-hot grant.
- The top level holds the FSM, shift register, bit counter and the two count accumulators.

## Test plan
Bench detector stub: `y_in` = x registered, `z_in` = ~x registered, both cleared asynchronously by `det_rst_n`.
- **Single frame**: req0 sends 8'hA5, `res_ready`=1.
  - `x_out` = 1,0,1,0,0,1,0,1.
  - `res_id`=0, `ycnt`=4, `zcnt`=4.
  - `res_valid` appears exactly 11 cycles after the grant cycle.
- **Tie**: both request from reset, req0=8'hFF, req1=8'h00.
  - The first result is id 0, `ycnt` 8, `zcnt` 0.
  - The second is id 1, `ycnt` 0, `zcnt` 8.
- **Fairness**: both hold `req_valid` for 6 frames → ids alternate 0,1,0,1,0,1.
- **Backpressure**: `res_ready`=0 for 20 cycles after `res_valid`.
  - Outputs stay stable and no new `req_ready` is issued.
  - The next grant comes the cycle after the handshake.
- **Clear**: `det_rst_n` is low for exactly one cycle per frame, always in the cycle immediately before the first SHIFT bit.
- **Reset mid-SHIFT**: assert `rst` at bit 3 of 8'hF0.
  - All outputs return to reset values immediately.
  - No result is produced.
  - The next frame (8'h0F) gives `ycnt`=4, `zcnt`=4.
